// File: rtl/frame_mem_arbiter.sv
// Single-port frame-buffer arbiter: VGA scan-out reads have priority, the two sprite
// writers share the leftover slots round-robin, and a per-writer starvation guard pre-empts VGA.
module frame_mem_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic [DATA_W-1:0] vga_rd_data,
  output logic              vga_rd_valid,
  output logic              vga_rd_miss,

  input  logic              w0_req,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  output logic              w0_ack,

  input  logic              w1_req,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  output logic              w1_ack,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned   CntW   = 8;
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              w0_ack_q, w0_ack_d;
  logic              w1_ack_q, w1_ack_d;
  logic              rr_last_q, rr_last_d;
  logic [CntW-1:0]   cnt0_q, cnt0_d;
  logic [CntW-1:0]   cnt1_q, cnt1_d;
  logic              rd_p1_q, rd_p2_q, rd_valid_q;
  logic              miss_p1_q, miss_p2_q, miss_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic elig0, elig1, starve0, starve1;
  logic grant0, grant1, rd_issue;

  // A writer whose ack is high still shows its stale req; mask it out.
  assign elig0   = w0_req & ~w0_ack_q;
  assign elig1   = w1_req & ~w1_ack_q;
  assign starve0 = elig0 & (cnt0_q == CntMax);
  assign starve1 = elig1 & (cnt1_q == CntMax);

  // rr_last_q = 1 means w1 was served last, so w0 is preferred next.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    rd_issue = 1'b0;
    if (starve0 | starve1) begin
      if (starve0 & starve1) begin
        grant0 = rr_last_q;
        grant1 = ~rr_last_q;
      end else begin
        grant0 = starve0;
        grant1 = starve1;
      end
    end else if (vga_rd_req) begin
      rd_issue = 1'b1;
    end else if (elig0 & elig1) begin
      grant0 = rr_last_q;
      grant1 = ~rr_last_q;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  always_comb begin
    mem_we_d    = grant0 | grant1;
    w0_ack_d    = grant0;
    w1_ack_d    = grant1;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rr_last_d   = rr_last_q;
    if (grant0) begin
      mem_addr_d  = w0_addr;
      mem_wdata_d = w0_data;
      rr_last_d   = 1'b0;
    end else if (grant1) begin
      mem_addr_d  = w1_addr;
      mem_wdata_d = w1_data;
      rr_last_d   = 1'b1;
    end else if (rd_issue) begin
      mem_addr_d  = vga_rd_addr;
    end
  end

  always_comb begin
    cnt0_d = cnt0_q;
    if (grant0 || !w0_req) begin
      cnt0_d = '0;
    end else if (elig0 && (cnt0_q < CntMax)) begin
      cnt0_d = cnt0_q + 1'b1;
    end
    cnt1_d = cnt1_q;
    if (grant1 || !w1_req) begin
      cnt1_d = '0;
    end else if (elig1 && (cnt1_q < CntMax)) begin
      cnt1_d = cnt1_q + 1'b1;
    end
  end

  assign rd_data_d = rd_p2_q ? mem_rdata : rd_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      w0_ack_q    <= 1'b0;
      w1_ack_q    <= 1'b0;
      rr_last_q   <= 1'b1;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      w0_ack_q    <= w0_ack_d;
      w1_ack_q    <= w1_ack_d;
      rr_last_q   <= rr_last_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  // Read return: issue (E0) -> RAM address latch (E1) -> data capture (E2).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_p1_q    <= 1'b0;
      rd_p2_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      miss_p1_q  <= 1'b0;
      miss_p2_q  <= 1'b0;
      miss_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_p1_q    <= rd_issue;
      rd_p2_q    <= rd_p1_q;
      rd_valid_q <= rd_p2_q;
      miss_p1_q  <= vga_rd_req & (grant0 | grant1);
      miss_p2_q  <= miss_p1_q;
      miss_q     <= miss_p2_q;
      rd_data_q  <= rd_data_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign w0_ack       = w0_ack_q;
  assign w1_ack       = w1_ack_q;
  assign vga_rd_data  = rd_data_q;
  assign vga_rd_valid = rd_valid_q;
  assign vga_rd_miss  = miss_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a synchronous single-port RAM model.
module tb_frame_mem_arbiter;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              vga_rd_req;
  logic [ADDR_W-1:0] vga_rd_addr;
  logic [DATA_W-1:0] vga_rd_data;
  logic              vga_rd_valid;
  logic              vga_rd_miss;
  logic              w0_req, w1_req;
  logic [ADDR_W-1:0] w0_addr, w1_addr;
  logic [DATA_W-1:0] w0_data, w1_data;
  logic              w0_ack, w1_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  frame_mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_MAX(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga_rd_req(vga_rd_req),
    .vga_rd_addr(vga_rd_addr),
    .vga_rd_data(vga_rd_data),
    .vga_rd_valid(vga_rd_valid),
    .vga_rd_miss(vga_rd_miss),
    .w0_req(w0_req),
    .w0_addr(w0_addr),
    .w0_data(w0_data),
    .w0_ack(w0_ack),
    .w1_req(w1_req),
    .w1_addr(w1_addr),
    .w1_data(w1_data),
    .w1_ack(w1_ack),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    vga_rd_req = 1'b0; vga_rd_addr = '0;
    w0_req = 1'b0; w0_addr = '0; w0_data = '0;
    w1_req = 1'b0; w1_addr = '0; w1_data = '0;
    #2;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_acks", {30'd0, w1_ack, w0_ack}, 32'd0);
    chk("rst_rd", {30'd0, vga_rd_valid, vga_rd_miss}, 32'd0);
    #5 rst = 1'b1;
    tick();

    // Single w0 write, req held one extra cycle, data changed after grant.
    w0_req = 1'b1; w0_addr = 17'h00123; w0_data = 8'h5A;
    tick();
    chk("w0_we", 32'(mem_we), 32'd1);
    chk("w0_addr", 32'(mem_addr), 32'h123);
    chk("w0_wdata", 32'(mem_wdata), 32'h5A);
    chk("w0_ack", 32'(w0_ack), 32'd1);
    w0_data = 8'hFF;
    tick();
    chk("w0_no_second_we", 32'(mem_we), 32'd0);
    chk("w0_ack_one_cycle", 32'(w0_ack), 32'd0);
    chk("w0_wdata_held", 32'(mem_wdata), 32'h5A);
    w0_req = 1'b0;
    tick();

    // w1 writes 0x3C to 0x01000, then VGA reads it back with latency 2.
    w1_req = 1'b1; w1_addr = 17'h01000; w1_data = 8'h3C;
    tick();
    chk("w1_ack", 32'(w1_ack), 32'd1);
    chk("w1_addr", 32'(mem_addr), 32'h1000);
    w1_req = 1'b0;
    tick();
    vga_rd_req = 1'b1; vga_rd_addr = 17'h01000;
    tick();
    chk("rd_E0_addr", 32'(mem_addr), 32'h1000);
    chk("rd_E0_we", 32'(mem_we), 32'd0);
    vga_rd_req = 1'b0;
    tick();
    chk("rd_E1_valid", 32'(vga_rd_valid), 32'd0);
    tick();
    chk("rd_E2_valid", 32'(vga_rd_valid), 32'd1);
    chk("rd_E2_data", 32'(vga_rd_data), 32'h3C);
    tick();
    chk("rd_E3_valid", 32'(vga_rd_valid), 32'd0);

    // Both writers held: acks alternate starting with w0 (w1 served last).
    w0_req = 1'b1; w0_addr = 17'h00200; w0_data = 8'h11;
    w1_req = 1'b1; w1_addr = 17'h00300; w1_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_w0_ack", 32'(w0_ack), 32'((k % 2) == 0));
      chk("rr_w1_ack", 32'(w1_ack), 32'((k % 2) == 1));
    end
    w0_req = 1'b0; w1_req = 1'b0;
    tick();
    chk("rr_idle_we", 32'(mem_we), 32'd0);

    // Continuous VGA; w0 starves and pre-empts at edge 16.
    vga_rd_req = 1'b1; vga_rd_addr = 17'h00010;
    w0_req = 1'b1; w0_addr = 17'h00400; w0_data = 8'h77;
    for (int k = 0; k < 21; k++) begin
      tick();
      chk("st0_we", 32'(mem_we), 32'(k == 16));
      chk("st0_ack", 32'(w0_ack), 32'(k == 16));
      chk("st0_miss", 32'(vga_rd_miss), 32'(k == 18));
      chk("st0_valid", 32'(vga_rd_valid), 32'((k >= 2) && (k != 18)));
      if (k == 16) w0_req = 1'b0;
    end

    // Both writers starve together with rr_last=0: w1 then w0.
    w0_req = 1'b1; w1_req = 1'b1;
    for (int k = 0; k < 22; k++) begin
      tick();
      chk("st2_w1_ack", 32'(w1_ack), 32'(k == 16));
      chk("st2_w0_ack", 32'(w0_ack), 32'(k == 17));
      chk("st2_we", 32'(mem_we), 32'((k == 16) || (k == 17)));
      chk("st2_miss", 32'(vga_rd_miss), 32'((k == 18) || (k == 19)));
      chk("st2_valid", 32'(vga_rd_valid), 32'((k != 18) && (k != 19)));
      if (k == 16) w1_req = 1'b0;
      if (k == 17) w0_req = 1'b0;
    end

    // Reset mid-stream with VGA read and w0 pending.
    w0_req = 1'b1; w1_req = 1'b1;
    tick();
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_valid", 32'(vga_rd_valid), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_acks", {30'd0, w1_ack, w0_ack}, 32'd0);
    vga_rd_req = 1'b0;
    tick();
    #3 rst = 1'b1;
    tick();
    chk("post_rst_w0_ack", 32'(w0_ack), 32'd1);
    chk("post_rst_w1_ack", 32'(w1_ack), 32'd0);
    chk("post_rst_addr", 32'(mem_addr), 32'h400);
    w0_req = 1'b0; w1_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
